sine_mode_sequencer: RTL
========================

// Module: sine_mode_sequencer
// PURPOSE
//  Controller for the sine/cos averaging generator datapath (avg). Drives the
//  generator's dataeve/dataodd mode-select inputs from an automatic dwell
//  schedule or from explicit requests over a valid/ready handshake. Mode changes
//  take effect on generator phase-wrap boundaries, so a waveform period is never
//  cut mid-cycle. One instance sits beside each avg instance.
// PARAMETERS
//  DWELL_WRAPS   4   phase wraps spent in each scheduled mode before auto-advance (>=1)
//  WRAP_TIMEOUT  64  cycles a pending request waits for phase_wrap before forced apply (>=2)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  synchronous, active-high reset
//  start        in   1  pulse: begin scheduled sequencing
//  stop         in   1  level/pulse: return to IDLE
//  phase_wrap   in   1  1-cycle pulse from generator when its phase index wraps to 0
//  req_valid    in   1  manual mode request valid
//  req_mode     in   2  requested mode {dataodd,dataeve}
//  req_ready    out  1  request accepted when req_valid & req_ready
//  dataeve      out  1  mode bit 0 to generator
//  dataodd      out  1  mode bit 1 to generator
//  busy         out  1  high in any state other than IDLE
//  switch_pulse out  1  1-cycle pulse on the cycle new mode bits appear
//  timeout      out  1  sticky: a pending request was forced without phase_wrap
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, {dataodd,dataeve}=00, req_ready=0,
//    busy=0, switch_pulse=0, timeout=0, dwell/timeout counters=0.
//  - Schedule order: 01 -> 10 -> 11 -> 01 (wraps around; 00 never scheduled).
//  - IDLE: mode 00. start -> RUN; mode 01 and switch_pulse appear next cycle;
//    timeout cleared; dwell count = 0.
//  - RUN: req_ready=1 (0 if stop is high). Each phase_wrap increments dwell count.
//    phase_wrap with count==DWELL_WRAPS-1 -> next scheduled mode applied
//    (outputs change at T+1, switch_pulse at T+1), count -> 0.
//    Request handshake -> latch req_mode, go to PEND, timeout counter = 0.
//  - PEND: req_ready=0; count cycles. Apply latched mode on phase_wrap, or at
//    count==WRAP_TIMEOUT-1 (set timeout=1). After apply: dwell count=0, RUN;
//    schedule resumes from the successor of the applied mode (00 -> 01).
//  - Mode 00 may be requested; RUN then holds 00 until dwell expiry advances to 01.
//  - Priority: reset > stop > request handshake > dwell advance. Stop in any state
//    -> IDLE next cycle, mode 00, pending request discarded, no switch_pulse.
//  - Handshake and dwell expiry in the same cycle: request wins; advance dropped.
//  - Handshake coincident with phase_wrap: that wrap is not used for the apply;
//    PEND waits for the next phase_wrap.
//  - start while busy: ignored. Reset mid-PEND: request lost, IDLE.
//  - Applying a mode equal to the current one still pulses switch_pulse.
// CONFIGURATION
//  SINE_SEQ_WRAP_ALIGN_EN defined: behaviour above (wrap-aligned apply, timeout).
//  Not defined: PEND lasts exactly one cycle; latched mode applied unconditionally
//    (outputs change 2 cycles after handshake); timeout counter absent, timeout
//    tied 0; dwell auto-advance unchanged.
// TESTING (DWELL_WRAPS=4, WRAP_TIMEOUT=64, macro defined unless noted)
//  1 reset 2 cycles, start, phase_wrap every 50 cycles -> modes 01,10,11,01 each
//    held for 4 wraps; switch_pulse one cycle after every 4th wrap.
//  2 In RUN, req_mode=11 handshake, phase_wrap 10 cycles later -> mode 11 at
//    wrap+1, timeout=0, next auto mode 01 after 4 more wraps.
//  3 Request 10, no phase_wrap -> applied 64 cycles after entering PEND,
//    timeout=1 and stays 1 until start after stop.
//  4 Handshake and dwell-expiry wrap in same cycle -> no scheduled advance;
//    requested mode applied on next wrap; stop during PEND -> IDLE, mode 00,
//    busy=0, no switch_pulse.
//  5 Macro undefined: request 11 at cycle T -> mode 11 and switch_pulse at T+2
//    with no phase_wrap; timeout stays 0.
//  6 reset asserted mid-RUN with mode 10 -> all outputs at reset values next
//    cycle; start restarts at 01.

Source files
------------

// File: rtl/sine_mode_sequencer.sv
// sine_mode_sequencer: picks the avg generator's {dataodd,dataeve} mode from
// a dwell schedule or manual requests, switching only on phase-wrap boundaries.
//
// Parameters:
//   DWELL_WRAPS   phase wraps held per scheduled mode before auto-advance (>=1)
//   WRAP_TIMEOUT  cycles a pending request waits for phase_wrap (>=2)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   pulse, begin scheduled sequencing from IDLE
//   stop         in   return to IDLE, discarding any pending request
//   phase_wrap   in   1-cycle pulse when the generator phase wraps to 0
//   req_valid    in   manual mode request valid
//   req_mode     in   requested mode {dataodd,dataeve}
//   req_ready    out  request accepted on req_valid & req_ready
//   dataeve      out  mode bit 0
//   dataodd      out  mode bit 1
//   busy         out  not IDLE
//   switch_pulse out  1-cycle pulse when new mode bits appear
//   timeout      out  sticky, a request was forced without phase_wrap
//
// Build option:
//   SINE_SEQ_WRAP_ALIGN_EN  defined   -> requests wait for phase_wrap, with
//                                        timeout fallback
//                           undefined -> requests apply one cycle after PEND
//                                        entry, timeout tied 0
module sine_mode_sequencer #(
  parameter int unsigned DWELL_WRAPS  = 4,
  parameter int unsigned WRAP_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       phase_wrap,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  output logic       dataeve,
  output logic       dataodd,
  output logic       busy,
  output logic       switch_pulse,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  localparam int unsigned DW =
    (DWELL_WRAPS > 1) ? $clog2(DWELL_WRAPS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_WRAPS - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    lat_q, lat_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic          pulse_q, pulse_d;
  logic          hs;

`ifdef SINE_SEQ_WRAP_ALIGN_EN
  localparam int unsigned TW = $clog2(WRAP_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(WRAP_TIMEOUT - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          to_q, to_d;
`else
  localparam int unsigned unused_wrap_timeout = WRAP_TIMEOUT;
`endif

  // Schedule 01 -> 10 -> 11 -> 01; 00 resumes at 01.
  function automatic logic [1:0] succ(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      2'b01:   r = 2'b10;
      2'b10:   r = 2'b11;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  // Ready drops in the same cycle as stop so a request
  // is never acknowledged and then discarded.
  assign req_ready = rdy_q & ~stop;
  assign hs        = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lat_d   = lat_q;
    dwell_d = dwell_q;
    pulse_d = 1'b0;
`ifdef SINE_SEQ_WRAP_ALIGN_EN
    tcnt_d  = tcnt_q;
    to_d    = to_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
      mode_d  = 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            mode_d  = 2'b01;
            pulse_d = 1'b1;
            dwell_d = '0;
`ifdef SINE_SEQ_WRAP_ALIGN_EN
            to_d    = 1'b0;
`endif
          end
        end
        S_RUN: begin
          // A handshake beats a coincident dwell expiry
          // and consumes that wrap.
          if (hs) begin
            state_d = S_PEND;
            lat_d   = req_mode;
`ifdef SINE_SEQ_WRAP_ALIGN_EN
            tcnt_d  = '0;
`endif
          end else if (phase_wrap) begin
            if (dwell_q == DWELL_LAST) begin
              mode_d  = succ(mode_q);
              pulse_d = 1'b1;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
        S_PEND: begin
`ifdef SINE_SEQ_WRAP_ALIGN_EN
          if (phase_wrap || tcnt_q == TO_LAST) begin
            state_d = S_RUN;
            mode_d  = lat_q;
            pulse_d = 1'b1;
            dwell_d = '0;
            if (!phase_wrap) to_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`else
          state_d = S_RUN;
          mode_d  = lat_q;
          pulse_d = 1'b1;
          dwell_d = '0;
`endif
        end
        default: begin
          state_d = S_IDLE;
          mode_d  = 2'b00;
        end
      endcase
    end
    rdy_d  = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      lat_q   <= 2'b00;
      dwell_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
`ifdef SINE_SEQ_WRAP_ALIGN_EN
      tcnt_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lat_q   <= lat_d;
      dwell_q <= dwell_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
`ifdef SINE_SEQ_WRAP_ALIGN_EN
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign dataeve      = mode_q[0];
  assign dataodd      = mode_q[1];
  assign busy         = busy_q;
  assign switch_pulse = pulse_q;
`ifdef SINE_SEQ_WRAP_ALIGN_EN
  assign timeout      = to_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule
